// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint sampler and its xorshift64 PRNG.
package constraint_sampler_pkg;

  localparam int unsigned PRNG_W = 64;
  localparam logic [PRNG_W-1:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15;

  localparam int unsigned XS_A = 13;
  localparam int unsigned XS_B = 7;
  localparam int unsigned XS_C = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CHECK,
    ST_OFFER,
    ST_DONE
  } state_e;

  function automatic logic [PRNG_W-1:0] xorshift_step(input logic [PRNG_W-1:0] x);
    logic [PRNG_W-1:0] t;
    t = x ^ (x << XS_A);
    t = t ^ (t >> XS_B);
    t = t ^ (t << XS_C);
    return t;
  endfunction

endpackage

// File: rtl/xorshift64.sv
// xorshift64 PRNG register; a zero seed is replaced by SEED since all-zero is a fixed point.
module xorshift64
  import constraint_sampler_pkg::*;
#(
  parameter logic [PRNG_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [PRNG_W-1:0] seed,
  input  logic              advance,
  output logic [PRNG_W-1:0] value
);

  logic [PRNG_W-1:0] x_q, x_d;

  always_comb begin
    x_d = x_q;
    if (load) begin
      x_d = (seed == '0) ? SEED : seed;
    end else if (advance) begin
      x_d = xorshift_step(x_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= SEED;
    end else begin
      x_q <= x_d;
    end
  end

  assign value = x_q;

endmodule

// File: rtl/constraint_sampler.sv
// Rejection sampler: fills a candidate from the PRNG, asks the checker, and
// streams only satisfying candidates to the sink.
module constraint_sampler
  import constraint_sampler_pkg::*;
#(
  parameter int unsigned       CAND_W = 512,
  parameter int unsigned       TRY_W  = 20,
  parameter logic [PRNG_W-1:0] SEED   = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       n_samples,
  input  logic [TRY_W-1:0]  max_tries,
  input  logic              seed_load,
  input  logic [PRNG_W-1:0] seed,
  output logic [CAND_W-1:0] cand,
  input  logic              sat,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [CAND_W-1:0] s_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [TRY_W-1:0]  tries,
  output logic [15:0]       accepted
);

  localparam int unsigned WORDS = CAND_W / PRNG_W;
  localparam int unsigned FC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e              state_q, state_d;
  logic [FC_W-1:0]     fill_q, fill_d;
  logic [CAND_W-1:0]   cand_q, cand_d;
  logic [CAND_W-1:0]   sdata_q, sdata_d;
  logic [TRY_W-1:0]    tries_q, tries_d, tries_inc;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         nsamp_q, nsamp_d;
  logic [TRY_W-1:0]    maxt_q, maxt_d;
  logic                timeout_q, timeout_d;
  logic [PRNG_W-1:0]   prng;

  xorshift64 #(.SEED(SEED)) u_prng (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seed_load && (state_q == ST_IDLE)),
    .seed    (seed),
    .advance (state_q == ST_FILL),
    .value   (prng)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cand_d    = cand_q;
    sdata_d   = sdata_q;
    tries_d   = tries_q;
    acc_d     = acc_q;
    nsamp_d   = nsamp_q;
    maxt_d    = maxt_q;
    timeout_d = timeout_q;
    tries_inc = (tries_q == '1) ? tries_q : tries_q + TRY_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tries_d   = '0;
          acc_d     = '0;
          timeout_d = 1'b0;
          fill_d    = '0;
          nsamp_d   = n_samples;
          maxt_d    = max_tries;
          state_d   = (n_samples == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        // Earlier words move toward the MSBs; the last word drawn lands at var_0.
        cand_d = (cand_q << PRNG_W) | CAND_W'(prng);
        fill_d = fill_q + FC_W'(1);
        if (fill_q == FC_W'(WORDS - 1)) begin
          fill_d  = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        tries_d = tries_inc;
        if (sat) begin
          sdata_d = cand_q;
          state_d = ST_OFFER;
        end else if ((maxt_q != '0) && (tries_inc == maxt_q)) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_OFFER: begin
        if (s_ready) begin
          acc_d   = acc_q + 16'd1;
          tries_d = '0;
          state_d = (acc_q + 16'd1 == nsamp_q) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      fill_q    <= '0;
      cand_q    <= '0;
      sdata_q   <= '0;
      tries_q   <= '0;
      acc_q     <= '0;
      nsamp_q   <= '0;
      maxt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      cand_q    <= cand_d;
      sdata_q   <= sdata_d;
      tries_q   <= tries_d;
      acc_q     <= acc_d;
      nsamp_q   <= nsamp_d;
      maxt_q    <= maxt_d;
      timeout_q <= timeout_d;
    end
  end

  assign cand     = cand_q;
  assign s_data   = sdata_q;
  assign s_valid  = (state_q == ST_OFFER);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign timeout  = timeout_q;
  assign tries    = tries_q;
  assign accepted = acc_q;

endmodule

// File: doc/constraint_sampler.md
# constraint_sampler

Sequential stimulus source that drives a generated constraint-checker module. It produces random candidate variable assignments from an internal xorshift64 PRNG and presents each candidate on a packed bus to the checker. It reads back the checker's single satisfaction bit and emits only satisfying assignments on a valid/ready stream. It sits between the seed/control logic and the sample sink, and is the generating end of the checker's variable interface.

## Interface
- CAND_W, 512: packed candidate width; sum of all checker variable widths, padded up to a multiple of 64.
- TRY_W, 20: width of the tries counter and of max_tries.
- SEED, 64'h9E3779B97F4A7C15: PRNG reset value; also substituted for any loaded seed of 0.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- n_samples  in  16  number of satisfying samples to produce; latched at start.
- max_tries  in  TRY_W  rejection limit per sample; 0 = unlimited; latched at start.
- seed_load  in  1  load seed into PRNG; honoured only in IDLE.
- seed  in  64  seed value.
- cand  out  CAND_W  candidate assignment to checker; var_0 at LSBs, packed upward.
- sat  in  1  checker result, combinational from cand.
- s_valid  out  1  sample available.
- s_ready  in  1  sink accepts sample.
- s_data  out  CAND_W  satisfying assignment.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at run end.
- timeout  out  1  sticky; set when max_tries is exhausted, cleared on next accepted start.
- tries  out  TRY_W  rejected-plus-current tries for the current sample.
- accepted  out  16  samples handed off in the current run.

## Operation
- FSM states: IDLE, FILL, CHECK, OFFER, DONE.
- IDLE, start, n_samples != 0: latch limits; clear tries, accepted and timeout; go to FILL.
- IDLE, start, n_samples == 0: go to DONE.
- FILL: runs CAND_W/64 cycles. Each cycle, cand <= {cand[CAND_W-65:0], prng} and the PRNG advances once. Afterwards go to CHECK.
- PRNG step: x ^= x<<13; x ^= x>>7; x ^= x<<17. All shifts are logical and truncated to 64 bits.
- CHECK: one cycle. tries increments, saturating at all-ones.
  - sat = 1: s_data <= cand; go to OFFER.
  - sat = 0, max_tries != 0, and new tries == max_tries: set timeout; go to DONE.
  - Otherwise go to FILL.
- OFFER: s_valid = 1. s_data and cand are held stable, and the PRNG is frozen until s_ready.
  - On handshake: accepted++ and tries <= 0.
  - If accepted reaches n_samples, go to DONE; otherwise go to FILL.
- DONE: done = 1 for one cycle, then go to IDLE.
- start during busy is ignored. seed_load during busy is ignored.
- seed_load together with start in IDLE: the seed loads first, and the run uses the new seed.
- Loading seed == 0 loads SEED instead, because the all-zero PRNG state is forbidden.

## Timing
- Reset (asynchronous) forces IDLE, prng = SEED, and cand, s_data, s_valid, busy, done, timeout, tries, accepted all 0.
- Reset mid-run aborts immediately. No done pulse is produced.
- Cycle 0 = start accepted.
  - FILL runs cycles 1..CAND_W/64.
  - CHECK runs at cycle CAND_W/64+1.
  - First s_valid no earlier than cycle CAND_W/64+2 (cycle 10 at default).
- Cost per try: CAND_W/64 + 1 cycles.
- Handshake in OFFER at cycle t: the next FILL starts at t+1. The final handshake at t gives done at t+1.
- s_valid is never deasserted without a handshake.

## Structure
- Package constraint_sampler_pkg holds:
  - the state enum;
  - the default SEED;
  - the xorshift shift constants (13, 7, 17);
  - the PRNG word width of 64.
- Sub-module xorshift64 has ports clk, rst_n, load, seed, advance and value. It provides the zero-seed substitution.
- Top level holds the FSM, the cand shift register, the s_data register and the counters.

## Test plan
- sat tied 1, n_samples=3, s_ready=1, default CAND_W: s_valid at cycles 10, 20 and 30; done at 31; accepted=3; timeout=0.
- sat tied 0, max_tries=5: no s_valid; timeout=1 and done at cycle 46; tries=5.
- sat=1, s_ready low for 20 cycles in OFFER: s_valid stays 1, s_data and cand stay constant, PRNG does not advance. The release handshake completes the sample.
- seed_load seed=64'h1, two identical runs: identical s_data sequences. A seed=0 load yields the same sequence as after reset.
- rst_n pulled low in the 4th FILL cycle: all outputs 0 in the same cycle, no done pulse. A subsequent start runs normally from SEED.
- start with n_samples=0: done at cycle 1; s_valid never asserted; accepted=0.
